// File: rtl/ipd_pkg.sv
// Shared types and helpers for the inter-packet-delay round-robin scheduler.
// Holds the FSM state encoding, datapath widths and lane-slicing helper.
// No logic of its own; imported by the scheduler, its arbiter and interface users.
package ipd_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam int TIMER_W = 64;
   localparam int DELAY_W = 32;
   localparam int CNT_W   = 32;

   // Bit offset of lane idx inside a flattened bus whose lanes are width bits wide.
   function automatic int slice_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/ipd_rr_scheduler_if.sv
// AXI4-Stream bundle between the N source queues and the single egress.
// Pure wiring, no latency.
// Backpressure travels on m_axis_tready towards the sources via s_axis_tready.
interface ipd_rr_scheduler_if #(
   parameter int NUM_QUEUES = 4,
   parameter int DW         = 512,
   parameter int UW         = 128
);
   logic [NUM_QUEUES*DW-1:0]   s_axis_tdata;
   logic [NUM_QUEUES*DW/8-1:0] s_axis_tstrb;
   logic [NUM_QUEUES*UW-1:0]   s_axis_tuser;
   logic [NUM_QUEUES-1:0]      s_axis_tvalid;
   logic [NUM_QUEUES-1:0]      s_axis_tlast;
   logic [NUM_QUEUES-1:0]      s_axis_tready;

   logic [DW-1:0]              m_axis_tdata;
   logic [DW/8-1:0]            m_axis_tstrb;
   logic [UW-1:0]              m_axis_tuser;
   logic                       m_axis_tvalid;
   logic                       m_axis_tlast;
   logic                       m_axis_tready;

   // Scheduler view: consumes the queues, drives the egress.
   modport master (
      input  s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
      output s_axis_tready,
      output m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
      input  m_axis_tready
   );

   // Environment view: sources feeding the queues and the sink on the egress.
   modport slave (
      output s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
      input  s_axis_tready,
      input  m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
      output m_axis_tready
   );
endinterface

// File: rtl/ipd_rr_arbiter.sv
// Round-robin pick of the first requester after last_grant, cyclically.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to sample the grant.
module ipd_rr_arbiter
   import ipd_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last_grant,
   output logic [N-1:0]         gnt_oh,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_vld
);

   logic [$clog2(N)-1:0] cand;

   // Scan last_grant+1 .. last_grant+N (mod N); the first requester wins.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      cand    = '0;
      for (int i = 1; i <= N; i++) begin
         cand = $clog2(N)'((int'(last_grant) + i) % N);
         if (!gnt_vld && req[cand]) begin
            gnt_vld      = 1'b1;
            gnt_idx      = cand;
            gnt_oh[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ipd_rr_scheduler.sv
// Shares one AXI4-Stream egress among N queues, each paced by its own inter-packet delay.
// Latency: zero-cycle pass-through while granted; one idle arbitration cycle per packet.
// Backpressure: m_axis_tready goes straight to the granted queue; nothing is buffered.
module ipd_rr_scheduler
   import ipd_pkg::*;
#(
   parameter int NUM_QUEUES            = 4,
   parameter int C_M_AXIS_DATA_WIDTH   = 512,
   parameter int C_S_AXIS_DATA_WIDTH   = 512,
   parameter int C_M_AXIS_TUSER_WIDTH  = 128,
   parameter int C_S_AXIS_TUSER_WIDTH  = 128,
   parameter int C_S_AXI_DATA_WIDTH    = 32,
   parameter int C_TUSER_TIMESTAMP_POS = 32
) (
   input  logic                                 axi_aclk,
   input  logic                                 axi_areset,
   input  logic                                 sw_rst,
   ipd_rr_scheduler_if.master                   axis,
   input  logic                                 sched_en,
   input  logic [NUM_QUEUES-1:0]                queue_en,
   input  logic [NUM_QUEUES-1:0]                use_reg_val,
   input  logic [NUM_QUEUES*C_S_AXI_DATA_WIDTH-1:0] delay_reg_val,
   output logic [NUM_QUEUES*CNT_W-1:0]          pkt_cnt
);

   localparam int IW  = $clog2(NUM_QUEUES);
   localparam int DWM = C_M_AXIS_DATA_WIDTH;
   localparam int DWS = C_S_AXIS_DATA_WIDTH;
   localparam int UWM = C_M_AXIS_TUSER_WIDTH;
   localparam int UWS = C_S_AXIS_TUSER_WIDTH;

   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [TIMER_W-1:0]   elig_time_q [NUM_QUEUES];
   logic [TIMER_W-1:0]   elig_time_d [NUM_QUEUES];
   logic [CNT_W-1:0]     pkt_cnt_q   [NUM_QUEUES];
   logic [CNT_W-1:0]     pkt_cnt_d   [NUM_QUEUES];
   logic [IW-1:0]        last_grant_q, last_grant_d;
   logic [IW-1:0]        grant_q, grant_d;
   logic [NUM_QUEUES-1:0] grant_oh_q, grant_oh_d;
   logic                 sop_q, sop_d;

   logic [NUM_QUEUES-1:0] elig;
   logic [NUM_QUEUES-1:0] gnt_oh;
   logic [IW-1:0]        gnt_idx;
   logic                 gnt_vld;
   logic                 beat;
   logic [DELAY_W-1:0]   delay_sel;

   // A queue may be picked once enabled, holding data and (when pacing) past its due time.
   always_comb begin
      elig = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         elig[q] = queue_en[q] & axis.s_axis_tvalid[q] &
                   (~sched_en | (timer_q >= elig_time_q[q]));
      end
   end

   ipd_rr_arbiter #(.N(NUM_QUEUES)) u_arb (
      .req        (elig),
      .last_grant (last_grant_q),
      .gnt_oh     (gnt_oh),
      .gnt_idx    (gnt_idx),
      .gnt_vld    (gnt_vld)
   );

   // Delay for the granted queue: register value or the field carried in its tuser.
   always_comb begin
      if (use_reg_val[grant_q]) begin
         delay_sel = delay_reg_val[slice_lsb(int'(grant_q), C_S_AXI_DATA_WIDTH) +: DELAY_W];
      end else begin
         delay_sel = axis.s_axis_tuser[slice_lsb(int'(grant_q), UWS) + C_TUSER_TIMESTAMP_POS +: DELAY_W];
      end
   end

   assign beat = axis.m_axis_tvalid & axis.m_axis_tready;

   // State register; async reset returns everything to idle at once.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         last_grant_q <= IW'(NUM_QUEUES - 1);
         grant_q      <= '0;
         grant_oh_q   <= '0;
         sop_q        <= 1'b1;
         for (int q = 0; q < NUM_QUEUES; q++) begin
            elig_time_q[q] <= '0;
            pkt_cnt_q[q]   <= '0;
         end
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         grant_oh_q   <= grant_oh_d;
         sop_q        <= sop_d;
         elig_time_q  <= elig_time_d;
         pkt_cnt_q    <= pkt_cnt_d;
      end
   end

   // Next state: arbitrate in IDLE, track packet start/end in SEND; sw_rst mirrors async reset.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q + TIMER_W'(1);
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      grant_oh_d   = grant_oh_q;
      sop_d        = sop_q;
      elig_time_d  = elig_time_q;
      pkt_cnt_d    = pkt_cnt_q;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               grant_d    = gnt_idx;
               grant_oh_d = gnt_oh;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (beat && sop_q) begin
               elig_time_d[grant_q] = timer_q + TIMER_W'(delay_sel);
               sop_d                = 1'b0;
            end
            if (beat && axis.m_axis_tlast) begin
               pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + CNT_W'(1);
               last_grant_d       = grant_q;
               sop_d              = 1'b1;
               state_d            = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (sw_rst) begin
         state_d      = IDLE;
         timer_d      = '0;
         last_grant_d = IW'(NUM_QUEUES - 1);
         grant_d      = '0;
         grant_oh_d   = '0;
         sop_d        = 1'b1;
         for (int q = 0; q < NUM_QUEUES; q++) begin
            elig_time_d[q] = '0;
            pkt_cnt_d[q]   = '0;
         end
      end
   end

   // Outputs: zero unless sending; while sending, the granted lane passes straight through.
   always_comb begin
      axis.m_axis_tdata  = '0;
      axis.m_axis_tstrb  = '0;
      axis.m_axis_tuser  = '0;
      axis.m_axis_tvalid = 1'b0;
      axis.m_axis_tlast  = 1'b0;
      axis.s_axis_tready = '0;
      if (state_q == SEND && !sw_rst) begin
         axis.m_axis_tdata  = axis.s_axis_tdata[slice_lsb(int'(grant_q), DWS) +: DWM];
         axis.m_axis_tstrb  = axis.s_axis_tstrb[slice_lsb(int'(grant_q), DWS/8) +: DWM/8];
         axis.m_axis_tuser  = axis.s_axis_tuser[slice_lsb(int'(grant_q), UWS) +: UWM];
         axis.m_axis_tvalid = axis.s_axis_tvalid[grant_q];
         axis.m_axis_tlast  = axis.s_axis_tlast[grant_q];
         axis.s_axis_tready = grant_oh_q & {NUM_QUEUES{axis.m_axis_tready}};
      end
   end

   // Flatten the per-queue packet counters onto the output bus.
   always_comb begin
      pkt_cnt = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         pkt_cnt[slice_lsb(q, CNT_W) +: CNT_W] = pkt_cnt_q[q];
      end
   end

endmodule

// File: tb/tb_ipd_rr_scheduler.sv
// Directed bench for ipd_rr_scheduler: table of round-robin grants plus hand-written
// sequences for pacing, tuser delay, backpressure, queue disable and async reset.
// Sources are modelled in the bench; every beat carries {queue, packet, beat} in tdata.
module tb_ipd_rr_scheduler;

   localparam int N  = 4;
   localparam int DW = 512;
   localparam int UW = 128;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic sw_rst = 1'b0;
   always #5 clk = ~clk;

   logic            sched_en;
   logic [N-1:0]    queue_en;
   logic [N-1:0]    use_reg_val;
   logic [N*32-1:0] delay_reg_val;
   logic [N*32-1:0] pkt_cnt;

   ipd_rr_scheduler_if #(.NUM_QUEUES(N), .DW(DW), .UW(UW)) axis ();

   ipd_rr_scheduler #(
      .NUM_QUEUES           (N),
      .C_M_AXIS_DATA_WIDTH  (DW),
      .C_S_AXIS_DATA_WIDTH  (DW),
      .C_M_AXIS_TUSER_WIDTH (UW),
      .C_S_AXIS_TUSER_WIDTH (UW)
   ) dut (
      .axi_aclk      (clk),
      .axi_areset    (rst),
      .sw_rst        (sw_rst),
      .axis          (axis),
      .sched_en      (sched_en),
      .queue_en      (queue_en),
      .use_reg_val   (use_reg_val),
      .delay_reg_val (delay_reg_val),
      .pkt_cnt       (pkt_cnt)
   );

   // Source model state
   int          beat [N];
   int          pkt  [N];
   int          len  [N];
   logic [31:0] tuser_dly [N];
   logic [N-1:0] vmask;
   bit          rdy_toggle;

   // Egress observation of the most recent cycle
   int   cyc;
   logic acc;
   int   acc_q, acc_beat, acc_cyc;
   logic acc_last;
   bit   prev_stall, stall_bad;
   logic [DW-1:0] prev_dat;

   int total, bad;

   typedef struct {
      logic [N-1:0] vmask;
      logic [N-1:0] qen;
      int           exp_q;
   } vec_t;
   vec_t vec [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] cnt(input int q);
      return pkt_cnt[q*32 +: 32];
   endfunction

   task automatic drive();
      for (int q = 0; q < N; q++) begin
         axis.s_axis_tdata[q*DW +: DW]     = '0;
         axis.s_axis_tdata[q*DW +: 32]     = {8'(q), 8'(pkt[q]), 16'(beat[q])};
         axis.s_axis_tstrb[q*DW/8 +: DW/8] = '1;
         axis.s_axis_tuser[q*UW +: UW]     = '0;
         axis.s_axis_tuser[q*UW +: 32]     = 32'(q);
         axis.s_axis_tuser[q*UW+32 +: 32]  = tuser_dly[q];
         axis.s_axis_tlast[q]              = (beat[q] == len[q] - 1);
         axis.s_axis_tvalid[q]             = vmask[q];
      end
      axis.m_axis_tready = rdy_toggle ? cyc[0] : 1'b1;
   endtask

   // One clock: observe at the falling edge, advance sources after the rising edge.
   task automatic tick();
      logic [N-1:0] fire;
      @(negedge clk);
      fire     = axis.s_axis_tready & axis.s_axis_tvalid;
      acc      = axis.m_axis_tvalid & axis.m_axis_tready;
      acc_q    = int'(axis.m_axis_tdata[31:24]);
      acc_beat = int'(axis.m_axis_tdata[15:0]);
      acc_last = axis.m_axis_tlast;
      acc_cyc  = cyc;
      if (prev_stall && axis.m_axis_tdata != prev_dat) stall_bad = 1'b1;
      prev_stall = axis.m_axis_tvalid & ~axis.m_axis_tready;
      prev_dat   = axis.m_axis_tdata;
      @(posedge clk);
      #1;
      cyc++;
      for (int q = 0; q < N; q++) begin
         if (fire[q]) begin
            if (beat[q] == len[q] - 1) begin
               beat[q] = 0;
               pkt[q]++;
            end else begin
               beat[q]++;
            end
         end
      end
      drive();
   endtask

   task automatic clear_sources();
      for (int q = 0; q < N; q++) begin
         beat[q] = 0;
         pkt[q]  = 0;
      end
      prev_stall = 1'b0;
   endtask

   task automatic do_reset(input bit use_sw);
      if (use_sw) sw_rst = 1'b1;
      else        rst    = 1'b1;
      clear_sources();
      drive();
      repeat (2) @(posedge clk);
      #1;
      sw_rst = 1'b0;
      rst    = 1'b0;
      drive();
   endtask

   // Collect one whole packet from the egress; to=1 if no tlast within the budget.
   task automatic run_pkt(input int budget, output int q, output int nb, output bit ord_ok,
                          output int sop_c, output int eop_c, output bit to);
      bit done;
      q = -1; nb = 0; ord_ok = 1'b1; sop_c = 0; eop_c = 0; to = 1'b1; done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         tick();
         if (acc) begin
            if (nb == 0) begin
               q     = acc_q;
               sop_c = acc_cyc;
            end else if (acc_q != q) begin
               ord_ok = 1'b0;
            end
            if (acc_beat != nb) ord_ok = 1'b0;
            nb++;
            if (acc_last) begin
               eop_c = acc_cyc;
               to    = 1'b0;
               done  = 1'b1;
            end
         end
      end
   endtask

   initial begin
      int q, nb, sc, ec, prev_ec, sc1, c0, n2;
      bit ok, to, found, seen3;

      total = 0; bad = 0; cyc = 0;
      rdy_toggle = 1'b0; stall_bad = 1'b0; prev_stall = 1'b0; prev_dat = '0;
      for (int i = 0; i < N; i++) begin
         len[i] = 2;
         tuser_dly[i] = '0;
      end
      clear_sources();
      sched_en = 1'b0; queue_en = '1; use_reg_val = '1; delay_reg_val = '0;
      vmask = '1;
      drive();

      // Reset state with every queue offering data.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tready", axis.s_axis_tready, 0);
      check("rst_mvalid", axis.m_axis_tvalid, 0);
      check("rst_mlast", axis.m_axis_tlast, 0);
      check("rst_pkt_cnt", |pkt_cnt, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive();

      // Round-robin grants, queue_en masking, one bubble between 2-beat packets.
      vec[0]  = '{4'b1111, 4'b1111, 0};
      vec[1]  = '{4'b1111, 4'b1111, 1};
      vec[2]  = '{4'b1111, 4'b1111, 2};
      vec[3]  = '{4'b1111, 4'b1111, 3};
      vec[4]  = '{4'b1111, 4'b1111, 0};
      vec[5]  = '{4'b1010, 4'b1111, 1};
      vec[6]  = '{4'b1010, 4'b1111, 3};
      vec[7]  = '{4'b1010, 4'b1111, 1};
      vec[8]  = '{4'b1111, 4'b0111, 2};
      vec[9]  = '{4'b1111, 4'b0111, 0};
      vec[10] = '{4'b1111, 4'b0101, 2};
      vec[11] = '{4'b0001, 4'b1111, 0};
      prev_ec = 0;
      for (int i = 0; i < 12; i++) begin
         vmask    = vec[i].vmask;
         queue_en = vec[i].qen;
         drive();
         run_pkt(50, q, nb, ok, sc, ec, to);
         check($sformatf("rr_timeout[%0d]", i), to, 0);
         check($sformatf("rr_grant[%0d]", i), q, vec[i].exp_q);
         check($sformatf("rr_beats[%0d]", i), nb, 2);
         check($sformatf("rr_order[%0d]", i), ok, 1);
         if (i > 0) check($sformatf("rr_bubble[%0d]", i), sc - prev_ec, 2);
         prev_ec = ec;
      end
      check("rr_cnt0", cnt(0), 4);
      check("rr_cnt1", cnt(1), 3);
      check("rr_cnt2", cnt(2), 3);
      check("rr_cnt3", cnt(3), 2);

      // Pacing from register: q0 alone, delay 100, one-beat packets.
      // Next start is 100 cycles after the previous plus the arbitration bubble.
      sched_en = 1'b1; queue_en = '1; use_reg_val = 4'b0001;
      delay_reg_val = '0; delay_reg_val[31:0] = 32'd100;
      for (int i = 0; i < N; i++) len[i] = 1;
      vmask = 4'b0001;
      do_reset(1'b1);
      check("swrst_pkt_cnt", |pkt_cnt, 0);
      run_pkt(20, q, nb, ok, sc1, ec, to);
      check("pace_q_a", q, 0);
      run_pkt(300, q, nb, ok, sc, ec, to);
      check("pace_q_b", q, 0);
      check("pace_gap_1", sc - sc1, 101);
      sc1 = sc;
      run_pkt(300, q, nb, ok, sc, ec, to);
      check("pace_timeout", to, 0);
      check("pace_gap_2", sc - sc1, 101);
      check("pace_cnt0", cnt(0), 3);

      // tuser-carried delay 50 on q1; q2 (delay 0) fills the gap.
      use_reg_val = 4'b0100; delay_reg_val = '0;
      tuser_dly[1] = 32'd50;
      vmask = 4'b0110;
      do_reset(1'b0);
      run_pkt(20, q, nb, ok, sc1, ec, to);
      check("tuser_first_q", q, 1);
      n2 = 0; found = 1'b0; sc = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         run_pkt(10, q, nb, ok, sc, ec, to);
         if (q == 1) found = 1'b1;
         else if (q == 2) n2++;
      end
      check("tuser_q1_again", found, 1);
      check("tuser_gap", sc - sc1, 52);
      check("tuser_q2_fill", n2, 25);
      tuser_dly[1] = '0;

      // Backpressure mid-packet on q2: tready alternates, data holds while stalled.
      sched_en = 1'b0; use_reg_val = '1;
      len[2] = 4;
      vmask = 4'b0100;
      do_reset(1'b0);
      rdy_toggle = 1'b1; stall_bad = 1'b0;
      drive();
      run_pkt(60, q, nb, ok, sc, ec, to);
      check("bp_timeout", to, 0);
      check("bp_q", q, 2);
      check("bp_beats", nb, 4);
      check("bp_order", ok, 1);
      check("bp_hold", stall_bad, 0);
      check("bp_cnt2", cnt(2), 1);
      rdy_toggle = 1'b0;

      // queue_en[3] dropped during a q3 packet: it completes, then q3 stays out.
      for (int i = 0; i < N; i++) len[i] = 3;
      vmask = 4'b1000; queue_en = '1;
      do_reset(1'b0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (acc && acc_q == 3 && acc_beat == 0) found = 1'b1;
      end
      check("qen_q3_sop", found, 1);
      queue_en[3] = 1'b0;
      vmask = 4'b1001;
      drive();
      nb = 1; ok = 1'b1; found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (acc) begin
            if (acc_q != 3 || acc_beat != nb) ok = 1'b0;
            nb++;
            if (acc_last) found = 1'b1;
         end
      end
      check("qen_complete", found, 1);
      check("qen_beats", nb, 3);
      check("qen_order", ok, 1);
      seen3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run_pkt(20, q, nb, ok, sc, ec, to);
         if (q != 0) seen3 = 1'b1;
      end
      check("qen_q3_excluded", seen3, 0);
      queue_en[3] = 1'b1;
      drive();
      run_pkt(20, q, nb, ok, sc, ec, to);
      check("qen_q3_reenabled", q, 3);

      // Async reset in the middle of a q1 packet.
      sched_en = 1'b1; use_reg_val = '1;
      for (int i = 0; i < N; i++) begin
         delay_reg_val[i*32 +: 32] = 32'd30;
         len[i] = 4;
      end
      vmask = 4'b0011;
      do_reset(1'b0);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (acc && acc_q == 1 && acc_beat == 0) found = 1'b1;
      end
      check("ar_q1_sop", found, 1);
      tick();
      check("ar_cnt0_before", cnt(0), 1);
      rst = 1'b1;
      #1;
      check("ar_tready", axis.s_axis_tready, 0);
      check("ar_mvalid", axis.m_axis_tvalid, 0);
      check("ar_mlast", axis.m_axis_tlast, 0);
      check("ar_pkt_cnt", |pkt_cnt, 0);
      clear_sources();
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      c0 = cyc;
      drive();
      run_pkt(20, q, nb, ok, sc, ec, to);
      check("ar_first_q", q, 0);
      check("ar_first_sop", sc - c0, 1);
      run_pkt(20, q, nb, ok, sc, prev_ec, to);
      check("ar_second_q", q, 1);
      check("ar_second_gap", sc - ec, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
